// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative RV32M multiply/divide unit for the EX stage.
// Shift-add multiply and restoring divide on operand magnitudes, one
// iteration per cycle for 32 cycles; divide-by-zero and signed overflow
// finish in a single cycle. Stalls the front of the pipeline while working.
module ex_muldiv (
    input  logic        clk,
    input  logic        rst,
    input  logic        md_start,
    input  logic [2:0]  md_op,
    input  logic [31:0] md_op_a,
    input  logic [31:0] md_op_b,
    input  logic        flush,
    output logic        md_stall,
    output logic        md_busy,
    output logic        md_done,
    output logic [31:0] md_result
);

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_REM    = 3'b110;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      state, state_nxt;
    logic [2:0]  op_q;
    logic [31:0] a_q, b_q;
    logic [4:0]  cnt;
    logic [63:0] acc;

    logic        accept, special;
    logic [31:0] special_res;
    logic        in_neg_a, in_neg_b;
    logic [31:0] in_mag_a, in_mag_b;
    logic        neg_a, neg_b;
    logic [31:0] mag_a, mag_b;
    logic [32:0] mul_sum, div_trial, div_diff;
    logic [63:0] acc_nxt, prod_s;
    logic [31:0] quot_s, rem_s, final_res;

    function automatic logic a_is_signed(input logic [2:0] op);
        return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic b_is_signed(input logic [2:0] op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    // Incoming operand magnitudes and single-cycle special-case detection
    always_comb begin
        accept   = (state == IDLE) && md_start && !flush && !rst;
        in_neg_a = a_is_signed(md_op) & md_op_a[31];
        in_neg_b = b_is_signed(md_op) & md_op_b[31];
        in_mag_a = in_neg_a ? 32'd0 - md_op_a : md_op_a;
        in_mag_b = in_neg_b ? 32'd0 - md_op_b : md_op_b;
        special  = md_op[2] && ((md_op_b == '0) ||
                   (!md_op[0] && (md_op_a == 32'h8000_0000) && (md_op_b == '1)));
        if (md_op_b == '0)
            special_res = md_op[1] ? md_op_a : '1;
        else
            special_res = md_op[1] ? '0 : 32'h8000_0000;
    end

    // One multiply or divide iteration plus sign fix-up of the finished value.
    // acc holds {partial product, multiplier} for MUL* and {remainder, quotient} for DIV*.
    always_comb begin
        neg_a     = a_is_signed(op_q) & a_q[31];
        neg_b     = b_is_signed(op_q) & b_q[31];
        mag_a     = neg_a ? 32'd0 - a_q : a_q;
        mag_b     = neg_b ? 32'd0 - b_q : b_q;
        mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, mag_a} : 33'd0);
        div_trial = {acc[63:32], acc[31]};
        div_diff  = div_trial - {1'b0, mag_b};
        if (!op_q[2])
            acc_nxt = {mul_sum, acc[31:1]};
        else if (!div_diff[32])
            acc_nxt = {div_diff[31:0], acc[30:0], 1'b1};
        else
            acc_nxt = {div_trial[31:0], acc[30:0], 1'b0};
        prod_s = (neg_a ^ neg_b) ? 64'd0 - acc_nxt : acc_nxt;
        quot_s = (neg_a ^ neg_b) ? 32'd0 - acc_nxt[31:0] : acc_nxt[31:0];
        rem_s  = neg_a ? 32'd0 - acc_nxt[63:32] : acc_nxt[63:32];
        if (!op_q[2])
            final_res = (op_q == OP_MUL) ? prod_s[31:0] : prod_s[63:32];
        else
            final_res = op_q[1] ? rem_s : quot_s;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = special ? DONE : CALC;
            CALC: begin
                if (flush)
                    state_nxt = IDLE;
                else if (cnt == 5'd31)
                    state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake outputs; a flush in DONE suppresses the completion pulse
    always_comb begin
        md_busy  = (state != IDLE);
        md_stall = accept || (state == CALC);
        md_done  = (state == DONE) && !flush;
    end

    // Operand latch, iteration datapath and result register
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            cnt       <= '0;
            acc       <= '0;
            md_result <= '0;
        end else if (accept) begin
            op_q <= md_op;
            a_q  <= md_op_a;
            b_q  <= md_op_b;
            cnt  <= '0;
            acc  <= {32'd0, md_op[2] ? in_mag_a : in_mag_b};
            if (special)
                md_result <= special_res;
        end else if ((state == CALC) && !flush) begin
            acc <= acc_nxt;
            cnt <= cnt + 5'd1;
            if (cnt == 5'd31)
                md_result <= final_res;
        end
    end

endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: self-checking bench for ex_muldiv with a cycle-level
// behavioural model, directed RV32M corner cases and randomized traffic.
module tb_ex_muldiv;

    logic        clk = 1'b0;
    logic        rst;
    logic        md_start;
    logic [2:0]  md_op;
    logic [31:0] md_op_a;
    logic [31:0] md_op_b;
    logic        flush;
    logic        md_stall;
    logic        md_busy;
    logic        md_done;
    logic [31:0] md_result;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    ex_muldiv dut (
        .clk       (clk),
        .rst       (rst),
        .md_start  (md_start),
        .md_op     (md_op),
        .md_op_a   (md_op_a),
        .md_op_b   (md_op_b),
        .flush     (flush),
        .md_stall  (md_stall),
        .md_busy   (md_busy),
        .md_done   (md_done),
        .md_result (md_result)
    );

    // Architectural result of an RV32M op using plain 64-bit arithmetic
    function automatic logic [31:0] ref_calc(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
        longint          sa, sb, p;
        longint unsigned ua, ub, up;
        int              ia, ib, iq;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        ia = $signed(a);
        ib = $signed(b);
        case (op)
            3'd0: begin up = ua * ub; return up[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * longint'(ub); return p[63:32]; end
            3'd3: begin up = ua * ub; return up[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                iq = ia / ib;
                return iq;
            end
            3'd5: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                iq = ia % ib;
                return iq;
            end
            default: begin
                if (b == 32'd0) return a;
                return a % b;
            end
        endcase
    endfunction

    // Ops that finish one cycle after acceptance
    function automatic bit one_cycle_op(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
        if (op < 3'd4) return 1'b0;
        if (b == 32'd0) return 1'b1;
        return (op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] gen_operand();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
        end
    endtask

    // Count cycles after the acceptance edge until md_done; -1 if it never comes
    task automatic wait_done(output int lat);
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (md_done) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input int exp_lat, input string name);
        int lat;
        @(posedge clk);
        #1;
        md_op    = op;
        md_op_a  = a;
        md_op_b  = b;
        md_start = 1'b1;
        @(negedge clk);
        chk({name, "_stall0"}, 32'(md_stall), 32'd1);
        @(posedge clk);
        wait_done(lat);
        chk({name, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({name, "_res"}, md_result, exp_res);
        @(posedge clk);
        #1;
        md_start = 1'b0;
    endtask

    // Cycle-level model: compare every cycle, then advance on the coming edge
    initial begin
        bit          m_active;
        int          m_left;
        logic [31:0] m_pending;
        logic [31:0] m_result;
        bit          e_done;
        bit          e_stall;
        m_active  = 1'b0;
        m_left    = 0;
        m_pending = '0;
        m_result  = '0;
        @(posedge clk);
        forever begin
            @(negedge clk);
            cyc++;
            e_done  = m_active && (m_left == 0) && !flush;
            e_stall = (m_active && m_left > 0) || (!m_active && md_start && !flush && !rst);
            chk("md_busy",   32'(md_busy),  32'(m_active));
            chk("md_done",   32'(md_done),  32'(e_done));
            chk("md_stall",  32'(md_stall), 32'(e_stall));
            chk("md_result", md_result,     m_result);
            if (rst) begin
                m_active = 1'b0;
                m_result = '0;
            end else if (!m_active) begin
                if (md_start && !flush) begin
                    m_active  = 1'b1;
                    m_pending = ref_calc(md_op, md_op_a, md_op_b);
                    if (one_cycle_op(md_op, md_op_a, md_op_b)) begin
                        m_left   = 0;
                        m_result = m_pending;
                    end else begin
                        m_left = 32;
                    end
                end
            end else if (m_left == 0 || flush) begin
                m_active = 1'b0;
            end else begin
                m_left--;
                if (m_left == 0)
                    m_result = m_pending;
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
        $fatal(1);
    end

    initial begin
        int lat;
        rst      = 1'b1;
        md_start = 1'b0;
        flush    = 1'b0;
        md_op    = '0;
        md_op_a  = '0;
        md_op_b  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_busy",   32'(md_busy),  32'd0);
        chk("reset_done",   32'(md_done),  32'd0);
        chk("reset_stall",  32'(md_stall), 32'd0);
        chk("reset_result", md_result,     32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Hand-computed values that pin the reference model
        chk("model_mul",    ref_calc(3'd0, 32'hFFFF_FFFE, 32'd3), 32'hFFFF_FFFA);
        chk("model_mulhsu", ref_calc(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFF);
        chk("model_div",    ref_calc(3'd4, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);
        chk("model_rem",    ref_calc(3'd6, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);

        run_op(3'd0, 32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFA, 33, "mul");
        run_op(3'd0, 32'd7,         32'd6,        32'd42,        33, "mul_small");
        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33, "mulh");
        run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, "mulhsu");
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, "mulhu");
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 33, "div");
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 33, "rem");
        run_op(3'd5, 32'd7,         32'd2,        32'd3,         33, "divu");
        run_op(3'd5, 32'd5,         32'd0,        32'hFFFF_FFFF, 1,  "divu_by0");
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1,  "div_ovf");
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1,  "rem_ovf");
        run_op(3'd4, 32'h0000_0055, 32'd0,        32'hFFFF_FFFF, 1,  "div_by0");
        run_op(3'd7, 32'h1234_5678, 32'd0,        32'h1234_5678, 1,  "remu_by0");

        // Flush at iteration 10 of a MUL
        @(posedge clk);
        #1;
        md_op    = 3'd0;
        md_op_a  = 32'h0000_1234;
        md_op_b  = 32'h0000_5678;
        md_start = 1'b1;
        @(posedge clk);
        repeat (10) @(posedge clk);
        #1;
        flush    = 1'b1;
        md_start = 1'b0;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        chk("flush_busy",   32'(md_busy),  32'd0);
        chk("flush_stall",  32'(md_stall), 32'd0);
        chk("flush_done",   32'(md_done),  32'd0);
        chk("flush_result", md_result,     32'h1234_5678);
        repeat (40) @(posedge clk);
        run_op(3'd3, 32'h0001_0000, 32'h0001_0000, 32'd1, 33, "after_flush");

        // Reset at iteration 20 with md_start held throughout
        @(posedge clk);
        #1;
        md_op    = 3'd5;
        md_op_a  = 32'd1000;
        md_op_b  = 32'd7;
        md_start = 1'b1;
        @(posedge clk);
        repeat (20) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_busy",   32'(md_busy),  32'd0);
        chk("rst_done",   32'(md_done),  32'd0);
        chk("rst_stall",  32'(md_stall), 32'd0);
        chk("rst_result", md_result,     32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        wait_done(lat);
        chk("rst_restart_lat", 32'(lat), 32'd33);
        chk("rst_restart_res", md_result, 32'd142);
        @(posedge clk);
        #1;
        md_start = 1'b0;

        // Random traffic: operands and op change every cycle, occasional flush/reset
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk);
            #1;
            rst      = ($urandom_range(0, 299) == 0);
            flush    = ($urandom_range(0, 49) == 0);
            md_start = ($urandom_range(0, 3) != 0);
            md_op    = 3'($urandom_range(0, 7));
            md_op_a  = gen_operand();
            md_op_b  = gen_operand();
        end
        @(posedge clk);
        #1;
        rst      = 1'b0;
        flush    = 1'b0;
        md_start = 1'b0;
        repeat (40) @(posedge clk);
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ex_muldiv.md
EX_MULDIV -- requirements
Module: ex_muldiv

Interface
REQ-001 SHALL have one clock; reset is synchronous and active-high.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 md_start  input  1  EX holds an M-extension op; level signal, held until md_done.
REQ-005 md_op  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 md_op_a  input  32  rs1 operand, already forwarded.
REQ-007 md_op_b  input  32  rs2 operand, already forwarded.
REQ-008 flush  input  1  branch/jump flush of EX; aborts the current op.
REQ-009 md_stall  output  1  freeze IF/ID/EX pipeline registers.
REQ-010 md_busy  output  1  FSM not in IDLE.
REQ-011 md_done  output  1  one-cycle pulse; md_result valid.
REQ-012 md_result  output  32  result, held until next accepted op.

Function
REQ-013 SHALL implement FSM states IDLE, CALC, DONE.
REQ-014 IDLE: md_start=1 and flush=0 SHALL latch md_op, md_op_a and md_op_b, then go to CALC with iteration counter 0, or directly to DONE for special cases (REQ-019, REQ-020).
REQ-015 CALC SHALL perform one iteration per cycle for exactly 32 cycles, then go to DONE.
REQ-016 DONE SHALL assert md_done for one cycle, then go to IDLE.
REQ-017 Multiply: shift-add on operand magnitudes, 64-bit product.
- Signedness per op: MULH both signed; MULHSU a signed, b unsigned; MULHU both unsigned.
- Final product negated when operand signs differ.
- MUL returns product[31:0]; MULH* return product[63:32].
REQ-018 Divide: restoring division on magnitudes.
- Quotient sign = sign(a) XOR sign(b).
- Remainder sign = sign(a).
- DIV/REM signed; DIVU/REMU unsigned.
REQ-019 Divide by zero (b=0) SHALL skip CALC.
- DIV/DIVU: result 0xFFFFFFFF.
- REM/REMU: result = a.
- md_done in the cycle after acceptance.
REQ-020 Signed overflow (DIV/REM, a=0x80000000, b=0xFFFFFFFF) SHALL skip CALC.
- DIV: result 0x80000000.
- REM: result 0.
REQ-021 Latency:
- Normal op accepted at edge N: md_done=1 during cycle N+33.
- Special case: md_done=1 during cycle N+1.
REQ-022 md_stall = (IDLE and md_start and not flush) or CALC; deasserted in DONE so EX advances exactly once with md_result.
REQ-023 md_busy = state != IDLE.
REQ-024 md_start while busy SHALL be ignored; latched operands SHALL not change mid-op.
REQ-025 flush in CALC or DONE: next state IDLE, no md_done pulse, md_result unchanged.
REQ-026 flush and md_start in the same IDLE cycle: flush wins, no op accepted.
REQ-027 md_start still high in the cycle after DONE SHALL start a new op (back-to-back ops allowed).
REQ-028 md_result SHALL update only on the DONE transition.

Reset
REQ-029 rst=1 at an edge SHALL force:
- state IDLE, counter 0;
- md_done, md_busy, md_stall, md_result all 0;
- latched operands 0.
REQ-030 rst mid-CALC SHALL abandon the op with no md_done pulse; the first op after rst deassertion SHALL behave normally.

Verification
REQ-031 MUL a=0xFFFFFFFE, b=3 -> md_done in cycle 33 after acceptance, md_result=0xFFFFFFFA; md_stall high for cycles 0-32.
REQ-032 MULH/MULHSU/MULHU with a=0xFFFFFFFF, b=0xFFFFFFFF -> results 0x00000000 / 0xFFFFFFFF / 0xFFFFFFFE respectively.
REQ-033 DIV a=-7 (0xFFFFFFF9), b=2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU a=7, b=2 -> 3.
REQ-034 DIVU a=5, b=0 -> 0xFFFFFFFF with md_done in the cycle after acceptance; DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000, 1-cycle latency.
REQ-035 Start MUL, assert flush at iteration 10 -> IDLE next cycle, no md_done, md_stall low; a new op then completes correctly.
REQ-036 Assert rst at iteration 20 -> all outputs 0 next cycle; md_start held continuously -> op restarts after deassertion, md_done 33 cycles after acceptance.
